// File: rtl/eth_rx_pkt_buf.sv
// Store-and-forward receive packet buffer: frames become visible only once
// their term beat is committed; cancelled or overflowing frames never leave.
module eth_rx_pkt_buf #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W/8+1),
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + LEN_W + 2;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_q, wr_d, cm_q, cm_d, rd_q;
  logic [PW-1:0]     wa;
  logic [15:0]       drop_q, drop_d;
  logic [16:0]       dsum;
  logic [1:0]        inc;
  logic              we, full, cfull, load;
  logic              valid_q, start_q, last_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic [EW-1:0]     mem [DEPTH];

  assign full  = (wr_q - rd_q) == PW'(DEPTH);
  // After a restart the open frame is discarded, so space is judged from cm.
  assign cfull = (cm_q - rd_q) == PW'(DEPTH);
  assign load  = (cm_q != rd_q) && (!valid_q || ready_i);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    wa      = wr_q;
    we      = 1'b0;
    inc     = 2'd0;
    if (cancel_i) begin
      wr_d    = cm_q;
      state_d = IDLE;
      if (state_q != IDLE) inc = 2'd1;
    end else if (valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (full) begin
              inc     = 2'd1;
              state_d = term_i ? IDLE : DROP;
            end else begin
              we      = 1'b1;
              state_d = term_i ? IDLE : RECV;
            end
          end
        end
        RECV: begin
          if (start_i) begin
            inc  = 2'd1;
            wr_d = cm_q;
            wa   = cm_q;
            if (cfull) begin
              inc     = 2'd2;
              state_d = term_i ? IDLE : DROP;
            end else begin
              we      = 1'b1;
              state_d = term_i ? IDLE : RECV;
            end
          end else if (full) begin
            inc     = 2'd1;
            wr_d    = cm_q;
            state_d = term_i ? IDLE : DROP;
          end else begin
            we = 1'b1;
            if (term_i) state_d = IDLE;
          end
        end
        DROP: begin
          if (start_i && !full) begin
            we      = 1'b1;
            state_d = term_i ? IDLE : RECV;
          end else if (term_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (we) begin
      wr_d = wa + PW'(1);
      if (term_i) cm_d = wa + PW'(1);
    end
  end

  assign dsum   = {1'b0, drop_q} + {15'd0, inc};
  assign drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];

  always_ff @(posedge clk) begin
    if (we) mem[wa[AW-1:0]] <= {data_i, len_i, start_i, term_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      drop_q  <= drop_d;
      if (load) begin
        rd_q    <= rd_q + PW'(1);
        valid_q <= 1'b1;
        {data_q, len_q, start_q, last_q} <= mem[rd_q[AW-1:0]];
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o    = valid_q;
  assign start_o    = start_q;
  assign last_o     = last_q;
  assign data_o     = data_q;
  assign len_o      = len_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_eth_rx_pkt_buf.sv
// Bench for eth_rx_pkt_buf: queue-based frame model compared every cycle,
// plus directed frames with literal expectations.
module tb_eth_rx_pkt_buf;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;
  localparam int DEPTH  = 64;
  localparam int M_IDLE = 0;
  localparam int M_RECV = 1;
  localparam int M_DROP = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cancel_i = 1'b0, valid_i = 1'b0;
  logic              start_i = 1'b0, term_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [LEN_W-1:0]  len_i = 2'd1;
  logic              ready_i = 1'b1;
  logic              valid_o, start_o, last_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic [15:0]       drop_cnt_o;

  always #5 clk = ~clk;

  eth_rx_pkt_buf #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cancel_i(cancel_i), .valid_i(valid_i),
    .start_i(start_i), .term_i(term_i), .data_i(data_i), .len_i(len_i),
    .ready_i(ready_i), .valid_o(valid_o), .start_o(start_o),
    .last_o(last_o), .data_o(data_o), .len_o(len_o),
    .drop_cnt_o(drop_cnt_o)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  l;
    logic        s;
    logic        t;
  } beat_t;

  beat_t cur[$];
  beat_t cq[$];
  beat_t acc[$];
  beat_t mout = '0;
  logic  mov = 1'b0;
  int    mdrop = 0;
  int    mst = M_IDLE;
  int    checks = 0;
  int    failures = 0;
  bit    rr = 1'b0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic void commit();
    foreach (cur[i]) cq.push_back(cur[i]);
    cur.delete();
  endfunction

  // Behavioural model: buffered frame contents as queues.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur.delete();
      cq.delete();
      mov = 1'b0;
      mout = '0;
      mdrop = 0;
      mst = M_IDLE;
    end else begin
      bit    full, cfull;
      int    inc;
      beat_t b;
      if (valid_o && ready_i)
        acc.push_back({data_o, len_o, start_o, last_o});
      full  = (cq.size() + cur.size()) == DEPTH;
      cfull = cq.size() == DEPTH;
      inc   = 0;
      b     = {data_i, len_i, start_i, term_i};
      if (cq.size() > 0 && (!mov || ready_i)) begin
        mout = cq.pop_front();
        mov  = 1'b1;
      end else if (ready_i) begin
        mov = 1'b0;
      end
      if (cancel_i) begin
        if (mst != M_IDLE) inc = 1;
        cur.delete();
        mst = M_IDLE;
      end else if (valid_i) begin
        if (mst == M_IDLE) begin
          if (start_i) begin
            if (full) begin
              inc = 1;
              mst = term_i ? M_IDLE : M_DROP;
            end else begin
              cur.push_back(b);
              if (term_i) commit();
              mst = term_i ? M_IDLE : M_RECV;
            end
          end
        end else if (mst == M_RECV) begin
          if (start_i) begin
            inc = 1;
            cur.delete();
            if (cfull) begin
              inc = 2;
              mst = term_i ? M_IDLE : M_DROP;
            end else begin
              cur.push_back(b);
              if (term_i) commit();
              mst = term_i ? M_IDLE : M_RECV;
            end
          end else if (full) begin
            inc = 1;
            cur.delete();
            mst = term_i ? M_IDLE : M_DROP;
          end else begin
            cur.push_back(b);
            if (term_i) begin
              commit();
              mst = M_IDLE;
            end
          end
        end else begin
          if (start_i && !full) begin
            cur.push_back(b);
            if (term_i) commit();
            mst = term_i ? M_IDLE : M_RECV;
          end else if (term_i) begin
            mst = M_IDLE;
          end
        end
      end
      mdrop = (mdrop + inc > 65535) ? 65535 : mdrop + inc;
    end
  end

  logic        pv = 1'b0;
  logic [20:0] prev_o = '0;

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    chk("valid_o", 32'(valid_o), 32'(mov));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(mdrop));
    if (mov) begin
      chk("data_o", 32'(data_o), 32'(mout.d));
      chk("len_o", 32'(len_o), 32'(mout.l));
      chk("start_o", 32'(start_o), 32'(mout.s));
      chk("last_o", 32'(last_o), 32'(mout.t));
    end
    if (pv && !ready_i && !reset)
      chk("stall_hold", 32'({valid_o, data_o, len_o, start_o, last_o}),
          32'(prev_o));
    pv     = valid_o && !reset;
    prev_o = {valid_o, data_o, len_o, start_o, last_o};
  end

  task automatic drv(input int v, input int st, input int tm, input int cn,
                     input int d, input int l);
    @(negedge clk);
    #1;
    valid_i  = (v != 0);
    start_i  = (st != 0);
    term_i   = (tm != 0);
    cancel_i = (cn != 0);
    data_i   = 16'(d);
    len_i    = 2'(l);
    if (rr) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    valid_i = 1'b0;
    cancel_i = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int flen;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    reset = 1'b0;

    // 3-beat frame with latency pinned
    acc.delete();
    drv(1, 1, 0, 0, 'h1111, 2);
    drv(1, 0, 0, 0, 'h2222, 2);
    drv(1, 0, 1, 0, 'h0033, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("lat_edge1", 32'(valid_o), 32'd0);
    drv(0, 0, 0, 0, 0, 1);
    chk("lat_edge2", 32'(valid_o), 32'd1);
    chk("b0_data", 32'(data_o), 32'h1111);
    chk("b0_start", 32'(start_o), 32'd1);
    drv(0, 0, 0, 0, 0, 1);
    chk("b1_data", 32'(data_o), 32'h2222);
    drv(0, 0, 0, 0, 0, 1);
    chk("b2_data", 32'(data_o), 32'h0033);
    chk("b2_last", 32'(last_o), 32'd1);
    chk("b2_len", 32'(len_o), 32'd1);
    idle(2);
    chk("f3_count", 32'(acc.size()), 32'd3);

    // cancel on beat 2, then a clean 2-beat frame
    acc.delete();
    drv(1, 1, 0, 0, 'hA001, 2);
    drv(1, 0, 0, 1, 'hA002, 2);
    drv(1, 0, 0, 0, 'hA003, 2);
    drv(1, 0, 1, 0, 'hA004, 2);
    drv(1, 1, 0, 0, 'hB001, 2);
    drv(1, 0, 1, 0, 'hB002, 1);
    idle(6);
    chk("cancel_drop", 32'(drop_cnt_o), 32'd1);
    chk("cancel_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      chk("cancel_b0", 32'(acc[0].d), 32'hB001);
      chk("cancel_last", 32'(acc[1].t), 32'd1);
    end

    // restart mid-frame
    acc.delete();
    drv(1, 1, 0, 0, 'hC001, 2);
    drv(1, 0, 0, 0, 'hC002, 2);
    drv(1, 1, 0, 0, 'hD001, 2);
    drv(1, 0, 0, 0, 'hD002, 2);
    drv(1, 0, 1, 0, 'hD003, 2);
    idle(6);
    chk("restart_drop", 32'(drop_cnt_o), 32'd2);
    chk("restart_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("restart_b0", 32'(acc[0].d), 32'hD001);
      chk("restart_s0", 32'(acc[0].s), 32'd1);
    end

    // fill with half-depth frames while stalled
    do_reset();
    acc.delete();
    ready_i = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < DEPTH/2; b++)
        drv(1, int'(b == 0), int'(b == DEPTH/2-1), 0, f*256 + b, 2);
    idle(4);
    chk("full_drop", 32'(drop_cnt_o), 32'd1);
    ready_i = 1'b1;
    idle(DEPTH + 10);
    chk("full_count", 32'(acc.size()), 32'(DEPTH));
    if (acc.size() == DEPTH) begin
      chk("full_first", 32'(acc[0].d), 32'h0000);
      chk("full_f1", 32'(acc[DEPTH/2].d), 32'h0100);
      chk("full_tail", 32'(acc[DEPTH-1].d), 32'(256 + DEPTH/2 - 1));
    end

    // reset mid-frame with a committed frame pending
    ready_i = 1'b0;
    drv(1, 1, 0, 0, 'hE001, 2);
    drv(1, 0, 1, 0, 'hE002, 2);
    drv(1, 1, 0, 0, 'hF001, 2);
    drv(1, 0, 0, 0, 'hF002, 2);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    reset = 1'b1;
    valid_i = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    chk("rst_mid_drop", 32'(drop_cnt_o), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    acc.delete();
    ready_i = 1'b1;
    drv(1, 1, 0, 0, 'h6001, 2);
    drv(1, 0, 1, 0, 'h6002, 1);
    idle(6);
    chk("post_rst_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) chk("post_rst_b0", 32'(acc[0].d), 32'h6001);

    // random frames, cancels, restarts and ready toggling
    rr = 1'b1;
    for (int f = 0; f < 100; f++) begin
      flen = ($urandom_range(0, 19) == 0) ? DEPTH + 6 : $urandom_range(1, 12);
      for (int b = 0; b < flen; b++) begin
        int st, cn, v;
        st = int'(b == 0 || $urandom_range(0, 39) == 0);
        cn = int'($urandom_range(0, 39) == 0);
        v  = (cn != 0) ? int'($urandom_range(0, 1)) : 1;
        drv(v, st, int'(b == flen - 1), cn, int'($urandom),
            int'($urandom_range(1, 2)));
      end
      idle(int'($urandom_range(0, 3)));
    end
    rr = 1'b0;
    ready_i = 1'b1;
    idle(DEPTH + 20);
    chk("drain_valid", 32'(valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
